prim_alert_sender_bank: RTL

PRIM_ALERT_SENDER_BANK -- requirements
Module: prim_alert_sender_bank

---
 rtl/prim_alert_sender_bank.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/prim_alert_sender_bank.sv
// Bank of independent differential alert senders with ping handling, integrity
// checking of the receiver pairs, and optional fatal (sticky) channels.

module prim_alert_sender_chan #(
   parameter bit Fatal = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic alert_req_i,
   input  logic alert_test_i,
   input  logic ack_p_i,
   input  logic ack_n_i,
   input  logic ping_p_i,
   input  logic ping_n_i,
   output logic alert_ack_o,
   output logic alert_state_o,
   output logic integ_fail_o,
   output logic alert_p_o,
   output logic alert_n_o
);

   typedef enum logic [2:0] {IDLE, HS1, HS2, PAUSE0, PAUSE1, SIGFAIL} state_e;

   state_e r_state, w_state_nxt;
   logic   r_ackq_p, r_ackq_n, r_pingq_p, r_pingq_n, r_pingq_d;
   logic   r_alert_pend, r_ping_pend, r_alert_fly;
   logic   r_alert_p, r_alert_n, r_ack;
   logic   w_integ, w_ping_ev, w_req, w_ack_hi, w_ack_lo;
   logic   w_alert_pend_nxt, w_ping_pend_nxt, w_alert_fly_nxt;
   logic   w_alert_p_nxt, w_alert_n_nxt, w_ack_nxt;

   assign w_integ   = (r_ackq_p == r_ackq_n) | (r_pingq_p == r_pingq_n);
   assign w_ping_ev = (r_pingq_p != r_pingq_d) & (r_pingq_p != r_pingq_n);
   assign w_req     = alert_req_i | alert_test_i;
   assign w_ack_hi  = r_ackq_p & ~r_ackq_n;
   assign w_ack_lo  = ~r_ackq_p & r_ackq_n;

   // Pends are handed to the in-flight handshake when it starts, so anything
   // arriving during the handshake stays pending for the next one.
   always_comb begin
      w_state_nxt      = r_state;
      w_alert_pend_nxt = r_alert_pend | w_req | w_integ;
      w_ping_pend_nxt  = r_ping_pend | w_ping_ev;
      w_alert_fly_nxt  = r_alert_fly;
      w_ack_nxt        = 1'b0;
      w_alert_p_nxt    = 1'b0;
      w_alert_n_nxt    = 1'b1;
      if (w_integ) begin
         w_state_nxt     = SIGFAIL;
         w_alert_fly_nxt = 1'b0;
         w_alert_p_nxt   = (r_state == SIGFAIL) ? ~r_alert_p : 1'b1;
         w_alert_n_nxt   = w_alert_p_nxt;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req | r_alert_pend | r_ping_pend) begin
                  w_state_nxt      = HS1;
                  w_alert_fly_nxt  = w_req | r_alert_pend;
                  w_alert_pend_nxt = Fatal & (r_alert_pend | w_req);
                  w_ping_pend_nxt  = w_ping_ev;
                  w_alert_p_nxt    = 1'b1;
                  w_alert_n_nxt    = 1'b0;
               end
            end
            HS1: begin
               if (w_ack_hi) begin
                  w_state_nxt = HS2;
               end else begin
                  w_alert_p_nxt = 1'b1;
                  w_alert_n_nxt = 1'b0;
               end
            end
            HS2: begin
               if (w_ack_lo) begin
                  w_state_nxt     = PAUSE0;
                  w_ack_nxt       = r_alert_fly;
                  w_alert_fly_nxt = 1'b0;
               end
            end
            PAUSE0:  w_state_nxt = PAUSE1;
            PAUSE1:  w_state_nxt = IDLE;
            SIGFAIL: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= IDLE;
         r_ackq_p     <= 1'b0;
         r_ackq_n     <= 1'b1;
         r_pingq_p    <= 1'b0;
         r_pingq_n    <= 1'b1;
         r_pingq_d    <= 1'b0;
         r_alert_pend <= 1'b0;
         r_ping_pend  <= 1'b0;
         r_alert_fly  <= 1'b0;
         r_alert_p    <= 1'b0;
         r_alert_n    <= 1'b1;
         r_ack        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_ackq_p     <= ack_p_i;
         r_ackq_n     <= ack_n_i;
         r_pingq_p    <= ping_p_i;
         r_pingq_n    <= ping_n_i;
         r_pingq_d    <= r_pingq_p;
         r_alert_pend <= w_alert_pend_nxt;
         r_ping_pend  <= w_ping_pend_nxt;
         r_alert_fly  <= w_alert_fly_nxt;
         r_alert_p    <= w_alert_p_nxt;
         r_alert_n    <= w_alert_n_nxt;
         r_ack        <= w_ack_nxt;
      end
   end

   assign alert_ack_o   = r_ack;
   assign alert_state_o = r_alert_pend | r_alert_fly;
   assign integ_fail_o  = w_integ;
   assign alert_p_o     = r_alert_p;
   assign alert_n_o     = r_alert_n;

endmodule

module prim_alert_sender_bank #(
   parameter int unsigned          NumAlerts = 4,
   parameter logic [NumAlerts-1:0] IsFatal   = '0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NumAlerts-1:0] alert_req_i,
   input  logic [NumAlerts-1:0] alert_test_i,
   output logic [NumAlerts-1:0] alert_ack_o,
   output logic [NumAlerts-1:0] alert_state_o,
   output logic [NumAlerts-1:0] integ_fail_o,
   input  logic [NumAlerts-1:0] ack_p_i,
   input  logic [NumAlerts-1:0] ack_n_i,
   input  logic [NumAlerts-1:0] ping_p_i,
   input  logic [NumAlerts-1:0] ping_n_i,
   output logic [NumAlerts-1:0] alert_p_o,
   output logic [NumAlerts-1:0] alert_n_o
);

   for (genvar g = 0; g < int'(NumAlerts); g++) begin : g_chan
      prim_alert_sender_chan #(.Fatal(IsFatal[g])) u_chan (
         .clk_i        (clk_i),
         .rst_i        (rst_i),
         .alert_req_i  (alert_req_i[g]),
         .alert_test_i (alert_test_i[g]),
         .ack_p_i      (ack_p_i[g]),
         .ack_n_i      (ack_n_i[g]),
         .ping_p_i     (ping_p_i[g]),
         .ping_n_i     (ping_n_i[g]),
         .alert_ack_o  (alert_ack_o[g]),
         .alert_state_o(alert_state_o[g]),
         .integ_fail_o (integ_fail_o[g]),
         .alert_p_o    (alert_p_o[g]),
         .alert_n_o    (alert_n_o[g])
      );
   end

endmodule
